// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default widths for the pipeline stall sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    localparam int MAX_WAIT_DEF = 16;
    localparam int WAIT_W_DEF   = 5;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    // count qualified events, holding at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (inc && q != '1)
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer: merges hazard and data-memory handshake into pipeline enables/flush
module pipeline_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hz,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ctrl_pass,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              mem_busy;

    // an access is outstanding when the memory is asked but has not answered; a dropped
    // request while waiting counts as an abort and releases the pipeline like ready does
    assign mem_busy    = dmem_req && !dmem_ready;
    assign mem_timeout = (state == S_ERR);

    // state and wait-cycle registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    // next-state and output decode; reset forces a full freeze with no pipeline advance
    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ctrl_pass   = 1'b1;
        pipe_freeze = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ctrl_pass   = 1'b0;
            pipe_freeze = 1'b1;
        end else if (state == S_ERR) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ctrl_pass   = 1'b0;
            pipe_freeze = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_freeze = 1'b1;
            if (state == S_RUN) begin
                state_nx = S_DWAIT;
                wait_nx  = WAIT_W'(1);
            end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                state_nx = S_ERR;
            end else begin
                wait_nx = wait_cnt + 1'b1;
            end
        end else begin
            state_nx = S_RUN;
            wait_nx  = '0;
            if (load_use_hz) begin
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                ctrl_pass   = 1'b0;
            end else if (branch_taken) begin
                IF_ID_flush = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (IF_ID_flush),
        .q   (flush_cnt)
    );

endmodule
